// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and helpers for the RC4 key-search control path
//
// Holds the key width, the S-memory grant encoding and the sequencer state
// encoding, plus small decode helpers used to derive the registered outputs
// from the next state.
package rc4_pkg;

  localparam int KEY_W = 24;

  // S-memory owner as seen by the top-level address/data/wren mux.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INIT = 2'd1,
    GNT_SHUF = 2'd2,
    GNT_DEC  = 2'd3
  } grant_t;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_INIT_GO     = 4'd1,
    ST_INIT_WAIT   = 4'd2,
    ST_SHUF_GO     = 4'd3,
    ST_SHUF_WAIT   = 4'd4,
    ST_DEC_GO      = 4'd5,
    ST_DEC_WAIT    = 4'd6,
    ST_CHECK       = 4'd7,
    ST_NEXT_KEY    = 4'd8,
    ST_FOUND       = 4'd9,
    ST_EXHAUSTED   = 4'd10,
    ST_TIMEOUT_ERR = 4'd11
  } state_t;

  // Memory owner for a given state; each engine owns the memory for its
  // GO and WAIT states only.
  function automatic grant_t grant_for(input state_t s);
    case (s)
      ST_INIT_GO, ST_INIT_WAIT: grant_for = GNT_INIT;
      ST_SHUF_GO, ST_SHUF_WAIT: grant_for = GNT_SHUF;
      ST_DEC_GO,  ST_DEC_WAIT:  grant_for = GNT_DEC;
      default:                  grant_for = GNT_NONE;
    endcase
  endfunction

  // Idle and the three terminal states are the only non-busy states.
  function automatic logic is_busy(input state_t s);
    case (s)
      ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_TIMEOUT_ERR: is_busy = 1'b0;
      default:                                         is_busy = 1'b1;
    endcase
  endfunction

  function automatic logic is_go(input state_t s);
    case (s)
      ST_INIT_GO, ST_SHUF_GO, ST_DEC_GO: is_go = 1'b1;
      default:                           is_go = 1'b0;
    endcase
  endfunction

  function automatic logic is_wait(input state_t s);
    case (s)
      ST_INIT_WAIT, ST_SHUF_WAIT, ST_DEC_WAIT: is_wait = 1'b1;
      default:                                 is_wait = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - clearable up-counter with terminal-count flag for the watchdog
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   clr      in   synchronous clear; count is 0 in the cycle after clr
//   en       in   count enable (one increment per enabled cycle)
//   expired  out  high during the LIMIT-th consecutive enabled cycle after clr
module wait_timer #(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  // count reads 0 in the first enabled cycle, so the LIMIT-th enabled cycle
  // sees TERM; the owner leaves the waiting state on that same edge.
  assign expired = en && (count == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// rtl/rc4_key_search_ctrl.sv - RC4 key-search sequencer and S-memory arbiter
//
// Runs init, shuffle and decrypt engines in order for each candidate key,
// grants the single-port S memory to one engine at a time, and either stops
// on a valid decrypt or steps to the next key.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   start                              level; (re)start search from KEY_START
//   abort                              level; return to idle, key retained
//   key[23:0]                          current candidate key
//   init_start/shuf_start/dec_start    single-cycle engine start pulses
//   init_done/shuf_done/dec_done       engine completion pulses
//   dec_valid                          decrypt verdict, sampled with dec_done
//   grant[1:0]                         S-memory owner (0 none,1 init,2 shuf,3 dec)
//   busy/found/exhausted/timeout_err   status flags
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_LAST  = 24'h3FFFFF,
  parameter logic [KEY_W-1:0] KEY_STEP  = 24'h000001,
  parameter int               TIMEOUT   = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [KEY_W-1:0] key,
  output logic             init_start,
  output logic             shuf_start,
  output logic             dec_start,
  input  logic             init_done,
  input  logic             shuf_done,
  input  logic             dec_done,
  input  logic             dec_valid,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic             timeout_err
);

  state_t           state_q;
  state_t           state_d;
  logic [KEY_W-1:0] key_d;
  logic             valid_q;
  logic             valid_d;
  grant_t           grant_q;
  logic             wd_clr;
  logic             wd_en;
  logic             wd_expired;
  logic             last_key;

  // Evaluated one bit wider so key + KEY_STEP cannot wrap; equivalent to
  // key > KEY_LAST - KEY_STEP without underflow when KEY_STEP > KEY_LAST.
  assign last_key = ({1'b0, key} + {1'b0, KEY_STEP}) > {1'b0, KEY_LAST};

  // Every WAIT state is entered from its GO state, so clearing during GO
  // restarts the watchdog on each WAIT entry.
  assign wd_clr = is_go(state_q);
  assign wd_en  = is_wait(state_q);

  wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Next-state logic. abort overrides everything; done pulses are only
  // honoured in the WAIT state of the engine that currently owns memory.
  always_comb begin
    state_d = state_q;
    key_d   = key;
    valid_d = valid_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_TIMEOUT_ERR: begin
          if (start) begin
            state_d = ST_INIT_GO;
            key_d   = KEY_START;
          end
        end
        ST_INIT_GO: state_d = ST_INIT_WAIT;
        ST_INIT_WAIT: begin
          if (init_done) begin
            state_d = ST_SHUF_GO;
          end else if (wd_expired) begin
            state_d = ST_TIMEOUT_ERR;
          end
        end
        ST_SHUF_GO: state_d = ST_SHUF_WAIT;
        ST_SHUF_WAIT: begin
          if (shuf_done) begin
            state_d = ST_DEC_GO;
          end else if (wd_expired) begin
            state_d = ST_TIMEOUT_ERR;
          end
        end
        ST_DEC_GO: state_d = ST_DEC_WAIT;
        ST_DEC_WAIT: begin
          if (dec_done) begin
            state_d = ST_CHECK;
            valid_d = dec_valid;
          end else if (wd_expired) begin
            state_d = ST_TIMEOUT_ERR;
          end
        end
        ST_CHECK: begin
          if (valid_q) begin
            state_d = ST_FOUND;
          end else if (last_key) begin
            state_d = ST_EXHAUSTED;
          end else begin
            state_d = ST_NEXT_KEY;
          end
        end
        ST_NEXT_KEY: begin
          key_d   = key + KEY_STEP;
          state_d = ST_INIT_GO;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, key and every control output are registered; outputs are decoded
  // from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      key         <= KEY_START;
      valid_q     <= 1'b0;
      grant_q     <= GNT_NONE;
      init_start  <= 1'b0;
      shuf_start  <= 1'b0;
      dec_start   <= 1'b0;
      busy        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      key         <= key_d;
      valid_q     <= valid_d;
      grant_q     <= grant_for(state_d);
      init_start  <= (state_d == ST_INIT_GO);
      shuf_start  <= (state_d == ST_SHUF_GO);
      dec_start   <= (state_d == ST_DEC_GO);
      busy        <= is_busy(state_d);
      // Terminal states hold until start or abort, which makes these sticky.
      found       <= (state_d == ST_FOUND);
      exhausted   <= (state_d == ST_EXHAUSTED);
      timeout_err <= (state_d == ST_TIMEOUT_ERR);
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// tb/tb_rc4_key_search_ctrl.sv - directed self-checking bench for rc4_key_search_ctrl
module tb_rc4_key_search_ctrl;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NI-1:0] start, abort;
  logic [NI-1:0] init_start, shuf_start, dec_start;
  logic [NI-1:0] init_done, shuf_done, dec_done, dec_valid;
  logic [NI-1:0] m_init_done = '0, m_shuf_done = '0, m_dec_done = '0;
  logic [NI-1:0] x_init_done, x_shuf_done, x_dec_done;
  logic [NI-1:0] busy, found, exhausted, timeout_err;
  logic [NI-1:0] model_en, shuf_mute, hit_en;
  logic [23:0]   hit_key [NI];
  logic [23:0]   key [NI];
  logic [1:0]    grant [NI];

  int lat_init [NI];
  int lat_shuf [NI];
  int lat_dec  [NI];
  int icnt [NI];
  int scnt [NI];
  int dcnt [NI];
  int n_init [NI];
  int n_shuf [NI];
  int n_dec  [NI];
  logic [23:0] key_log [NI][16];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign init_done = m_init_done | x_init_done;
  assign shuf_done = m_shuf_done | x_shuf_done;
  assign dec_done  = m_dec_done  | x_dec_done;

  for (genvar g = 0; g < NI; g++) begin : g_valid
    assign dec_valid[g] = hit_en[g] && (key[g] == hit_key[g]);
  end

  // u0: single key, u1: hit search, u2: stepped search, u3: top-of-range + short watchdog
  rc4_key_search_ctrl #(.KEY_START(24'h000000), .KEY_LAST(24'h000000), .KEY_STEP(24'h000001), .TIMEOUT(1023)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .key(key[0]),
    .init_start(init_start[0]), .shuf_start(shuf_start[0]), .dec_start(dec_start[0]),
    .init_done(init_done[0]), .shuf_done(shuf_done[0]), .dec_done(dec_done[0]), .dec_valid(dec_valid[0]),
    .grant(grant[0]), .busy(busy[0]), .found(found[0]), .exhausted(exhausted[0]), .timeout_err(timeout_err[0]));

  rc4_key_search_ctrl #(.KEY_START(24'h000000), .KEY_LAST(24'h00000A), .KEY_STEP(24'h000001), .TIMEOUT(1023)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .key(key[1]),
    .init_start(init_start[1]), .shuf_start(shuf_start[1]), .dec_start(dec_start[1]),
    .init_done(init_done[1]), .shuf_done(shuf_done[1]), .dec_done(dec_done[1]), .dec_valid(dec_valid[1]),
    .grant(grant[1]), .busy(busy[1]), .found(found[1]), .exhausted(exhausted[1]), .timeout_err(timeout_err[1]));

  rc4_key_search_ctrl #(.KEY_START(24'h000000), .KEY_LAST(24'h00000A), .KEY_STEP(24'h000004), .TIMEOUT(1023)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .key(key[2]),
    .init_start(init_start[2]), .shuf_start(shuf_start[2]), .dec_start(dec_start[2]),
    .init_done(init_done[2]), .shuf_done(shuf_done[2]), .dec_done(dec_done[2]), .dec_valid(dec_valid[2]),
    .grant(grant[2]), .busy(busy[2]), .found(found[2]), .exhausted(exhausted[2]), .timeout_err(timeout_err[2]));

  rc4_key_search_ctrl #(.KEY_START(24'hFFFFFC), .KEY_LAST(24'hFFFFFF), .KEY_STEP(24'h000002), .TIMEOUT(16)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .abort(abort[3]), .key(key[3]),
    .init_start(init_start[3]), .shuf_start(shuf_start[3]), .dec_start(dec_start[3]),
    .init_done(init_done[3]), .shuf_done(shuf_done[3]), .dec_done(dec_done[3]), .dec_valid(dec_valid[3]),
    .grant(grant[3]), .busy(busy[3]), .found(found[3]), .exhausted(exhausted[3]), .timeout_err(timeout_err[3]));

  // Engine models: count start pulses, log the key seen with each init_start,
  // and answer with a one-cycle done after the configured latency.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      m_init_done[i] = 1'b0;
      m_shuf_done[i] = 1'b0;
      m_dec_done[i]  = 1'b0;
      if (init_start[i]) begin
        if (n_init[i] < 16) key_log[i][n_init[i]] = key[i];
        n_init[i]++;
        icnt[i] = lat_init[i];
      end else if (icnt[i] > 0) begin
        icnt[i]--;
        if (icnt[i] == 0 && model_en[i]) m_init_done[i] = 1'b1;
      end
      if (shuf_start[i]) begin
        n_shuf[i]++;
        scnt[i] = lat_shuf[i];
      end else if (scnt[i] > 0) begin
        scnt[i]--;
        if (scnt[i] == 0 && model_en[i] && !shuf_mute[i]) m_shuf_done[i] = 1'b1;
      end
      if (dec_start[i]) begin
        n_dec[i]++;
        dcnt[i] = lat_dec[i];
      end else if (dcnt[i] > 0) begin
        dcnt[i]--;
        if (dcnt[i] == 0 && model_en[i]) m_dec_done[i] = 1'b1;
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_assert++;
    if (grant[0] !== 2'd0 || busy[0] !== 1'b0 || init_start[0] !== 1'b0 || shuf_start[0] !== 1'b0 || dec_start[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: grant=%0d busy=%0b starts=%0b%0b%0b, required 0 0 000", grant[0], busy[0], init_start[0], shuf_start[0], dec_start[0]);
    end
    n_assert++;
    if (found[0] !== 1'b0 || exhausted[0] !== 1'b0 || timeout_err[0] !== 1'b0 || key[0] !== 24'h000000) begin
      n_fail++;
      $display("FAIL reset_flags: found=%0b exh=%0b to=%0b key=%h, required 0 0 0 000000", found[0], exhausted[0], timeout_err[0], key[0]);
    end
    n_assert++;
    if (key[3] !== 24'hFFFFFC) begin
      n_fail++;
      $display("FAIL reset_key_start: key=%h, required fffffc", key[3]);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_key();
    int bi, bs, bd, t;
    bi = n_init[0]; bs = n_shuf[0]; bd = n_dec[0];
    @(negedge clk); start[0] = 1'b1;
    @(posedge clk); #1;
    n_assert++;
    if (init_start[0] !== 1'b1 || grant[0] !== 2'd1 || busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL go_timing: init_start=%0b grant=%0d busy=%0b, required 1 1 1", init_start[0], grant[0], busy[0]);
    end
    @(negedge clk); start[0] = 1'b0;
    @(posedge clk); #1;
    n_assert++;
    if (init_start[0] !== 1'b0 || grant[0] !== 2'd1) begin
      n_fail++;
      $display("FAIL init_pulse_width: init_start=%0b grant=%0d, required 0 1", init_start[0], grant[0]);
    end
    t = 0;
    while (exhausted[0] !== 1'b1 && t < 3000) begin @(posedge clk); #1; t++; end
    n_assert++;
    if (exhausted[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_exhausted: exhausted=%0b after %0d cycles, required 1", exhausted[0], t);
    end
    n_assert++;
    if (key[0] !== 24'h000000 || grant[0] !== 2'd0 || busy[0] !== 1'b0 || found[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_final: key=%h grant=%0d busy=%0b found=%0b, required 000000 0 0 0", key[0], grant[0], busy[0], found[0]);
    end
    n_assert++;
    if (n_init[0] - bi !== 1 || n_shuf[0] - bs !== 1 || n_dec[0] - bd !== 1) begin
      n_fail++;
      $display("FAIL single_pulses: init=%0d shuf=%0d dec=%0d, required 1 1 1", n_init[0] - bi, n_shuf[0] - bs, n_dec[0] - bd);
    end
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if (exhausted[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL exhausted_sticky: exhausted=%0b, required 1", exhausted[0]);
    end
  endtask

  task automatic test_hit();
    int bi, t;
    bi = n_init[1];
    hit_en[1] = 1'b1; hit_key[1] = 24'h000003;
    @(negedge clk); start[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start[1] = 1'b0;
    t = 0;
    while (!(dec_done[1] === 1'b1 && key[1] === 24'h000003) && t < 3000) begin @(posedge clk); #1; t++; end
    n_assert++;
    if (busy[1] !== 1'b1 || found[1] !== 1'b0 || grant[1] !== 2'd0) begin
      n_fail++;
      $display("FAIL hit_check_cycle: busy=%0b found=%0b grant=%0d after %0d cycles, required 1 0 0", busy[1], found[1], grant[1], t);
    end
    @(posedge clk); #1;
    n_assert++;
    if (found[1] !== 1'b1 || key[1] !== 24'h000003 || grant[1] !== 2'd0 || busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_found: found=%0b key=%h grant=%0d busy=%0b, required 1 000003 0 0", found[1], key[1], grant[1], busy[1]);
    end
    n_assert++;
    if (n_init[1] - bi !== 4) begin
      n_fail++;
      $display("FAIL hit_init_count: init pulses=%0d, required 4", n_init[1] - bi);
    end
    repeat (5) @(posedge clk);
    #1;
    n_assert++;
    if (found[1] !== 1'b1 || key[1] !== 24'h000003) begin
      n_fail++;
      $display("FAIL hit_hold: found=%0b key=%h, required 1 000003", found[1], key[1]);
    end
    @(negedge clk); hit_en[1] = 1'b0; start[1] = 1'b1;
    @(posedge clk); #1;
    n_assert++;
    if (found[1] !== 1'b0 || init_start[1] !== 1'b1 || key[1] !== 24'h000000) begin
      n_fail++;
      $display("FAIL restart_from_found: found=%0b init_start=%0b key=%h, required 0 1 000000", found[1], init_start[1], key[1]);
    end
    @(negedge clk); start[1] = 1'b0; abort[1] = 1'b1;
    @(posedge clk); #1;
    n_assert++;
    if (busy[1] !== 1'b0 || grant[1] !== 2'd0) begin
      n_fail++;
      $display("FAIL abort_from_init: busy=%0b grant=%0d, required 0 0", busy[1], grant[1]);
    end
    @(negedge clk); abort[1] = 1'b0;
  endtask

  task automatic test_step();
    int bi, t;
    bi = n_init[2];
    @(negedge clk); start[2] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start[2] = 1'b0;
    t = 0;
    while (exhausted[2] !== 1'b1 && t < 2000) begin @(posedge clk); #1; t++; end
    n_assert++;
    if (exhausted[2] !== 1'b1 || key[2] !== 24'h000008) begin
      n_fail++;
      $display("FAIL step_exhausted: exhausted=%0b key=%h after %0d cycles, required 1 000008", exhausted[2], key[2], t);
    end
    n_assert++;
    if (n_init[2] - bi !== 3) begin
      n_fail++;
      $display("FAIL step_key_count: keys tried=%0d, required 3", n_init[2] - bi);
    end
    n_assert++;
    if (key_log[2][bi] !== 24'h000000 || key_log[2][bi+1] !== 24'h000004 || key_log[2][bi+2] !== 24'h000008) begin
      n_fail++;
      $display("FAIL step_key_seq: keys=%h %h %h, required 000000 000004 000008", key_log[2][bi], key_log[2][bi+1], key_log[2][bi+2]);
    end
  endtask

  task automatic test_overflow();
    int bi, t;
    bi = n_init[3];
    @(negedge clk); start[3] = 1'b1;
    @(posedge clk); #1;
    n_assert++;
    if (key[3] !== 24'hFFFFFC || init_start[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL top_first_key: key=%h init_start=%0b, required fffffc 1", key[3], init_start[3]);
    end
    @(negedge clk); start[3] = 1'b0;
    t = 0;
    while (exhausted[3] !== 1'b1 && t < 500) begin @(posedge clk); #1; t++; end
    n_assert++;
    if (exhausted[3] !== 1'b1 || key[3] !== 24'hFFFFFE || timeout_err[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL top_no_overflow: exhausted=%0b key=%h to=%0b, required 1 fffffe 0", exhausted[3], key[3], timeout_err[3]);
    end
    n_assert++;
    if (n_init[3] - bi !== 2) begin
      n_fail++;
      $display("FAIL top_key_count: keys tried=%0d, required 2", n_init[3] - bi);
    end
  endtask

  task automatic test_watchdog();
    int t;
    logic bad;
    shuf_mute[3] = 1'b1;
    @(negedge clk); start[3] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start[3] = 1'b0;
    t = 0;
    while (shuf_start[3] !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    bad = (shuf_start[3] !== 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (timeout_err[3] !== 1'b0 || grant[3] !== 2'd2) bad = 1'b1;
    end
    n_assert++;
    if (bad) begin
      n_fail++;
      $display("FAIL wd_hold: left SHUF_WAIT early or never entered, to=%0b grant=%0d, required 0 2 for 16 cycles", timeout_err[3], grant[3]);
    end
    @(posedge clk); #1;
    n_assert++;
    if (timeout_err[3] !== 1'b1 || grant[3] !== 2'd0 || busy[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_fire: to=%0b grant=%0d busy=%0b, required 1 0 0", timeout_err[3], grant[3], busy[3]);
    end
    shuf_mute[3] = 1'b0;
  endtask

  task automatic test_abort_stray();
    int t;
    @(negedge clk); start[2] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start[2] = 1'b0;
    t = 0;
    while (!(init_start[2] === 1'b1 && key[2] === 24'h000004) && t < 500) begin @(posedge clk); #1; t++; end
    model_en[2] = 1'b0;
    n_assert++;
    if (key[2] !== 24'h000004 || exhausted[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_second_key: key=%h exh=%0b after %0d cycles, required 000004 0", key[2], exhausted[2], t);
    end
    @(posedge clk); #1;
    x_init_done[2] = 1'b1;
    @(posedge clk); #1;
    n_assert++;
    if (shuf_start[2] !== 1'b1 || grant[2] !== 2'd2) begin
      n_fail++;
      $display("FAIL handshake_shuf_go: shuf_start=%0b grant=%0d, required 1 2", shuf_start[2], grant[2]);
    end
    x_init_done[2] = 1'b0;
    @(posedge clk); #1;
    x_dec_done[2] = 1'b1;
    @(posedge clk); #1;
    n_assert++;
    if (grant[2] !== 2'd2 || dec_start[2] !== 1'b0 || busy[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_dec_done: grant=%0d dec_start=%0b busy=%0b, required 2 0 1", grant[2], dec_start[2], busy[2]);
    end
    x_dec_done[2] = 1'b0; x_shuf_done[2] = 1'b1;
    @(posedge clk); #1;
    n_assert++;
    if (dec_start[2] !== 1'b1 || grant[2] !== 2'd3) begin
      n_fail++;
      $display("FAIL handshake_dec_go: dec_start=%0b grant=%0d, required 1 3", dec_start[2], grant[2]);
    end
    x_shuf_done[2] = 1'b0;
    @(posedge clk); #1;
    x_dec_done[2] = 1'b1; hit_en[2] = 1'b1; hit_key[2] = 24'h000004; abort[2] = 1'b1;
    @(posedge clk); #1;
    n_assert++;
    if (busy[2] !== 1'b0 || grant[2] !== 2'd0 || found[2] !== 1'b0 || key[2] !== 24'h000004) begin
      n_fail++;
      $display("FAIL abort_dec_wait: busy=%0b grant=%0d found=%0b key=%h, required 0 0 0 000004", busy[2], grant[2], found[2], key[2]);
    end
    x_dec_done[2] = 1'b0; abort[2] = 1'b0; hit_en[2] = 1'b0;
    @(posedge clk); #1;
    n_assert++;
    if (found[2] !== 1'b0 || busy[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stays_idle: found=%0b busy=%0b, required 0 0", found[2], busy[2]);
    end
    start[2] = 1'b1;
    @(posedge clk); #1;
    n_assert++;
    if (init_start[2] !== 1'b1 || key[2] !== 24'h000000) begin
      n_fail++;
      $display("FAIL restart_after_abort: init_start=%0b key=%h, required 1 000000", init_start[2], key[2]);
    end
    start[2] = 1'b0; abort[2] = 1'b1;
    @(posedge clk); #1;
    abort[2] = 1'b0;
    model_en[2] = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic bad;
    @(negedge clk); start[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start[0] = 1'b0;
    @(posedge clk); #1;
    n_assert++;
    if (grant[0] !== 2'd1 || busy[0] !== 1'b1 || exhausted[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_wait: grant=%0d busy=%0b exh=%0b, required 1 1 0", grant[0], busy[0], exhausted[0]);
    end
    #2;
    rst_n = 1'b0;
    start[0] = 1'b1;
    #1;
    n_assert++;
    if (grant[0] !== 2'd0 || busy[0] !== 1'b0 || init_start[0] !== 1'b0 || key[0] !== 24'h000000 || exhausted[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: grant=%0d busy=%0b init_start=%0b key=%h exh=%0b, required 0 0 0 000000 0", grant[0], busy[0], init_start[0], key[0], exhausted[0]);
    end
    n_assert++;
    if (key[3] !== 24'hFFFFFC || timeout_err[3] !== 1'b0 || exhausted[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_u3: key=%h to=%0b exh=%0b, required fffffc 0 0", key[3], timeout_err[3], exhausted[3]);
    end
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (init_start[0] !== 1'b0 || busy[0] !== 1'b0) bad = 1'b1;
    end
    n_assert++;
    if (bad) begin
      n_fail++;
      $display("FAIL start_during_reset: init_start=%0b busy=%0b, required 0 0", init_start[0], busy[0]);
    end
    @(negedge clk); start[0] = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    n_assert++;
    if (busy[0] !== 1'b0 || grant[0] !== 2'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%0b grant=%0d, required 0 0", busy[0], grant[0]);
    end
  endtask

  initial begin
    start = '0; abort = '0;
    x_init_done = '0; x_shuf_done = '0; x_dec_done = '0;
    model_en = '1; shuf_mute = '0; hit_en = '0;
    for (int i = 0; i < NI; i++) begin
      hit_key[i] = 24'h0;
      lat_init[i] = 20; lat_shuf[i] = 40; lat_dec[i] = 10;
    end
    lat_init[0] = 256; lat_shuf[0] = 768; lat_dec[0] = 64;
    lat_init[3] = 5;   lat_shuf[3] = 9;   lat_dec[3] = 3;

    test_reset();
    test_single_key();
    test_hit();
    test_step();
    test_overflow();
    test_watchdog();
    test_abort_stray();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
